// File: rtl/qk_seq_pkg.sv
// rtl/qk_seq_pkg.sv - shared types and inst bit positions for the Q·K instruction sequencer
package qk_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_Q,
    S_WR_K,
    S_LOAD_K,
    S_LOAD_END,
    S_SETTLE,
    S_EXEC,
    S_WAIT_OF,
    S_MOVE,
    S_DONE
  } state_e;

  localparam int INST_W        = 19;
  localparam int INST_DIV      = 18;
  localparam int INST_ACC      = 17;
  localparam int INST_OFIFO_RD = 16;
  localparam int QKADD_LSB     = 12;
  localparam int PADD_LSB      = 8;
  localparam int INST_EXECUTE  = 7;
  localparam int INST_LOAD     = 6;
  localparam int INST_QMEM_RD  = 5;
  localparam int INST_QMEM_WR  = 4;
  localparam int INST_KMEM_RD  = 3;
  localparam int INST_KMEM_WR  = 2;
  localparam int INST_PMEM_RD  = 1;
  localparam int INST_PMEM_WR  = 0;

  // Counter width large enough for the longest terminal count of any state.
  function automatic int cnt_width(input int col, input int add_w,
                                   input int settle_cycles, input int of_timeout);
    int m;
    m = col;
    if ((1 << add_w) > m) m = 1 << add_w;
    if (settle_cycles > m) m = settle_cycles;
    if (of_timeout > m) m = of_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/qk_seq_cnt.sv
// rtl/qk_seq_cnt.sv - loadable up-counter with terminal-count flag, reused by every sequencer state
module qk_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority so a state change always starts its count from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/qk_inst_sequencer.sv
// rtl/qk_inst_sequencer.sv - generates the fullchip inst word for one complete Q·K pass
module qk_inst_sequencer
  import qk_seq_pkg::*;
#(
  parameter int col           = 8,
  parameter int add_w         = 4,
  parameter int settle_cycles = 10,
  parameter int of_timeout    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [add_w:0]    num_q,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = cnt_width(col, add_w, settle_cycles, of_timeout);

  localparam logic [add_w:0] NQ_MAX = (add_w + 1)'(1 << add_w);
  localparam logic [CW-1:0]  COL_M1 = CW'(col - 1);
  localparam logic [CW-1:0]  COL_T  = CW'(col);
  localparam logic [CW-1:0]  SET_M1 = CW'(settle_cycles - 1);
  localparam logic [CW-1:0]  TO_M1  = CW'(of_timeout - 1);

  state_e         state_q, state_d;
  logic [add_w:0] nq_q, nq_d;
  logic           err_q, err_d;

  logic           cnt_clr;
  logic           cnt_inc;
  logic [CW-1:0]  cnt_term;
  logic [CW-1:0]  cnt_val;
  logic           cnt_tc;

  logic [CW-1:0]  nq_m1;
  logic           nq_ok;
  logic           beat;

  assign nq_m1    = CW'(nq_q) - CW'(1);
  assign nq_ok    = (num_q != '0) && (num_q <= NQ_MAX);
  assign in_ready = (state_q == S_WR_Q) || (state_q == S_WR_K);
  assign beat     = in_valid & in_ready;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;

  qk_seq_cnt #(
    .W (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .term  (cnt_term),
    .cnt   (cnt_val),
    .tc    (cnt_tc)
  );

  // State, latched Q count and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      nq_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nq_q    <= nq_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the shared counter is cleared on every state change.
  always_comb begin
    state_d  = state_q;
    nq_d     = nq_q;
    err_d    = err_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_term = nq_m1;
    unique case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (start && nq_ok) begin
          nq_d    = num_q;
          err_d   = 1'b0;
          state_d = S_WR_Q;
        end
      end
      S_WR_Q: begin
        cnt_term = nq_m1;
        if (beat) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = S_WR_K;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_WR_K: begin
        cnt_term = COL_M1;
        if (beat) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = S_LOAD_K;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_LOAD_K: begin
        cnt_term = COL_T;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = S_LOAD_END;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_LOAD_END: begin
        cnt_clr = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_term = SET_M1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = S_EXEC;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_EXEC: begin
        cnt_term = nq_m1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = S_WAIT_OF;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT_OF: begin
        cnt_term = TO_M1;
        if (ofifo_valid) begin
          cnt_clr = 1'b1;
          state_d = S_MOVE;
        end else if (cnt_tc) begin
          cnt_clr = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_MOVE: begin
        cnt_term = nq_m1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Instruction decode from registered state/count; only the write strobes follow the handshake.
  always_comb begin
    inst = '0;
    unique case (state_q)
      S_WR_Q: begin
        inst[QKADD_LSB +: add_w] = cnt_val[add_w-1:0];
        inst[INST_QMEM_WR]       = beat;
      end
      S_WR_K: begin
        inst[QKADD_LSB +: add_w] = cnt_val[add_w-1:0];
        inst[INST_KMEM_WR]       = beat;
      end
      S_LOAD_K: begin
        inst[INST_LOAD]    = 1'b1;
        inst[INST_KMEM_RD] = (cnt_val != '0);
        if (cnt_val > CW'(1)) begin
          inst[QKADD_LSB +: add_w] = cnt_val[add_w-1:0] - add_w'(1);
        end
      end
      S_LOAD_END: begin
        inst[INST_LOAD] = 1'b1;
      end
      S_EXEC: begin
        inst[INST_EXECUTE]       = 1'b1;
        inst[INST_QMEM_RD]       = 1'b1;
        inst[QKADD_LSB +: add_w] = cnt_val[add_w-1:0];
      end
      S_MOVE: begin
        inst[INST_OFIFO_RD]     = 1'b1;
        inst[INST_PMEM_WR]      = 1'b1;
        inst[PADD_LSB +: add_w] = cnt_val[add_w-1:0];
      end
      default: begin
        inst = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// tb/tb_qk_inst_sequencer.sv - self-checking bench for qk_inst_sequencer
module tb_qk_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  num_q;
  logic        in_valid;
  logic        in_ready;
  logic        ofifo_valid;
  logic [18:0] inst;
  logic        busy;
  logic        done;
  logic        err;

  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;
  logic e_err = 1'b0;

  typedef struct {
    logic [18:0] inst;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [4:0] nq;
    logic       acc;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  qk_inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_q       (num_q),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always @(negedge clk) begin
    #2;
    if (done === 1'b1) done_seen++;
  end

  function automatic logic [18:0] mk(input logic ofrd, input int qa, input int pa,
                                     input logic exe, input logic ld, input logic qrd,
                                     input logic qwr, input logic krd, input logic kwr,
                                     input logic pwr);
    logic [18:0] v;
    v       = '0;
    v[16]   = ofrd;
    v[15:12] = qa[3:0];
    v[11:8] = pa[3:0];
    v[7]    = exe;
    v[6]    = ld;
    v[5]    = qrd;
    v[4]    = qwr;
    v[3]    = krd;
    v[2]    = kwr;
    v[0]    = pwr;
    return v;
  endfunction

  task automatic cyc(input logic rst_v, input logic st, input logic [4:0] nq,
                     input logic iv, input logic ov, input logic [18:0] e_inst,
                     input logic e_rdy, input logic e_busy, input logic e_done,
                     input string tag);
    exp_t e;
    @(negedge clk);
    reset       = rst_v;
    start       = st;
    num_q       = nq;
    in_valid    = iv;
    ofifo_valid = ov;
    e.inst = e_inst;
    e.rdy  = e_rdy;
    e.busy = e_busy;
    e.done = e_done;
    e.err  = e_err;
    e.tag  = tag;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({inst, in_ready, busy, done, err} !== {e.inst, e.rdy, e.busy, e.done, e.err}) begin
      errors++;
      $display("FAIL %s: got inst=%h rdy=%b busy=%b done=%b err=%b, want inst=%h rdy=%b busy=%b done=%b err=%b",
               e.tag, inst, in_ready, busy, done, err, e.inst, e.rdy, e.busy, e.done, e.err);
    end
  endtask

  task automatic run_pass(input int nq, input int stall, input int of_delay,
                          input int abort_exec, input int move_start, input string tag);
    int   a;
    int   k;
    logic iv;
    cyc(1'b1, 1'b1, nq[4:0], 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, {tag, " start"});
    e_err = 1'b0;
    a = 0;
    k = 0;
    while (a < nq) begin
      iv = (stall != 0) ? (k % 3 == 0) : 1'b1;
      cyc(1'b1, 1'b0, 5'd0, iv, 1'b0, mk(0, a, 0, 0, 0, 0, iv, 0, 0, 0), 1'b1, 1'b1, 1'b0, {tag, " wr_q"});
      if (iv) a++;
      k++;
    end
    a = 0;
    while (a < 8) begin
      iv = (stall != 0) ? (k % 3 == 0) : 1'b1;
      cyc(1'b1, 1'b0, 5'd0, iv, 1'b0, mk(0, a, 0, 0, 0, 0, 0, 0, iv, 0), 1'b1, 1'b1, 1'b0, {tag, " wr_k"});
      if (iv) a++;
      k++;
    end
    for (int p = 0; p <= 8; p++) begin
      cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, mk(0, (p <= 1) ? 0 : p - 1, 0, 0, 1, 0, 0, p >= 1, 0, 0),
          1'b0, 1'b1, 1'b0, {tag, " load_k"});
    end
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, {tag, " load_end"});
    for (int s = 0; s < 10; s++) begin
      cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, '0, 1'b0, 1'b1, 1'b0, {tag, " settle"});
    end
    for (int i = 0; i < nq; i++) begin
      if (i == abort_exec) begin
        e_err = 1'b0;
        cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, {tag, " reset low"});
        cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, {tag, " reset held"});
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, {tag, " reset release"});
        return;
      end
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, mk(0, i, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, {tag, " exec"});
    end
    if (of_delay < 0) begin
      for (int w = 0; w < 64; w++) begin
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, {tag, " wait_of"});
      end
      e_err = 1'b1;
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, {tag, " timeout idle"});
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, {tag, " timeout idle2"});
      return;
    end
    for (int w = 0; w <= of_delay; w++) begin
      cyc(1'b1, 1'b0, 5'd0, 1'b0, (w == of_delay), '0, 1'b0, 1'b1, 1'b0, {tag, " wait_of"});
    end
    for (int i = 0; i < nq; i++) begin
      cyc(1'b1, (move_start != 0) && (i == 1), nq[4:0], 1'b1, (i == 0),
          mk(1, 0, i, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b1, 1'b0, {tag, " move"});
    end
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, {tag, " done"});
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, {tag, " idle after"});
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    num_q       = '0;
    in_valid    = 1'b0;
    ofifo_valid = 1'b0;

    tbl[0] = '{nq: 5'd0,  acc: 1'b0};
    tbl[1] = '{nq: 5'd17, acc: 1'b0};
    tbl[2] = '{nq: 5'd31, acc: 1'b0};
    tbl[3] = '{nq: 5'd1,  acc: 1'b1};
    tbl[4] = '{nq: 5'd16, acc: 1'b1};
    tbl[5] = '{nq: 5'd8,  acc: 1'b1};

    cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "reset");
    cyc(1'b0, 1'b1, 5'd8, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, "reset with inputs");
    cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "idle in_valid ignored");

    for (int v = 0; v < 6; v++) begin
      cyc(1'b1, 1'b1, tbl[v].nq, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "tbl start");
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, tbl[v].acc, tbl[v].acc, 1'b0, "tbl next");
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, tbl[v].acc, tbl[v].acc, 1'b0, "tbl hold");
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "tbl reset");
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "tbl release");
    end

    run_pass(8,  0,  3, -1, 0, "basic");
    run_pass(4,  1,  0, -1, 0, "stall");
    run_pass(8,  0, -1, -1, 0, "timeout");
    run_pass(2,  0,  1, -1, 0, "clear err");
    run_pass(16, 0,  0, -1, 0, "nq16");
    run_pass(1,  0,  2, -1, 0, "nq1");
    run_pass(8,  0,  3,  3, 0, "abort");
    run_pass(8,  0,  3, -1, 0, "after abort");
    run_pass(8,  0,  2, -1, 1, "start in move");

    @(negedge clk);
    #3;
    checks++;
    if (done_seen != 7) begin
      errors++;
      $display("FAIL done count: got %0d pulses, want 7", done_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
